// File: rtl/dvp_pattern_source.sv
// OV7670-style DVP emulator: pclk = clk/2, vsync/href framing and RGB444 byte
// pairs for four selectable test patterns, all state advancing on pclk falling edges.
`timescale 1ns/1ps
module dvp_pattern_source #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BP        = 17,
    parameter int V_FP        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       pclk_o,
    output logic       vsync_o,
    output logic       href_o,
    output logic [7:0] dout,
    output logic       frame_done
);
    localparam int L     = 2 * H_ACTIVE + H_BLANK;
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t      r_state, w_state_nxt, w_first, w_after_vs;
    logic        r_pclk, r_vsync, r_href, r_fd;
    logic [7:0]  r_dout, w_dout_nxt;
    logic [15:0] r_bx, r_ly, w_bx_nxt, w_ly_nxt, w_lines;
    logic [1:0]  r_pat;
    logic [11:0] r_pix, w_rgb;
    logic [15:0] r_bar_cnt;
    logic [2:0]  r_bar;
    logic        w_tick, w_line_end, w_state_end, w_in_line, w_byte1;
    logic        w_start, w_frame_end, w_vsync_nxt, w_href_nxt, w_fd_nxt;

    assign w_tick      = r_pclk;
    assign w_line_end  = (r_bx == 16'(L - 1));
    assign w_state_end = w_line_end && (r_ly == w_lines - 16'd1);
    assign w_in_line   = (r_bx < 16'(2 * H_ACTIVE));
    assign w_byte1     = (r_state == ACTIVE) && w_in_line && r_bx[0];

    // Zero-length vertical regions are skipped entirely
    always_comb begin
        w_after_vs = (V_BP > 0) ? VBP : ACTIVE;
        w_first    = (VSYNC_LINES > 0) ? VSYNC : w_after_vs;
        case (r_state)
            VSYNC:   w_lines = 16'(VSYNC_LINES);
            VBP:     w_lines = 16'(V_BP);
            ACTIVE:  w_lines = 16'(V_ACTIVE);
            VFP:     w_lines = 16'(V_FP);
            default: w_lines = 16'd1;
        endcase
    end

    always_comb begin
        w_rgb = r_pix;
        case (r_pat)
            2'd0: begin
                case (r_bar)
                    3'd0: w_rgb = 12'hFFF;
                    3'd1: w_rgb = 12'hFF0;
                    3'd2: w_rgb = 12'h0FF;
                    3'd3: w_rgb = 12'h0F0;
                    3'd4: w_rgb = 12'hF0F;
                    3'd5: w_rgb = 12'hF00;
                    3'd6: w_rgb = 12'h00F;
                    3'd7: w_rgb = 12'h000;
                endcase
            end
            2'd1: w_rgb = {3{r_bx[8:5]}};
            2'd2: w_rgb = (r_bx[5] ^ r_ly[4]) ? 12'hFFF : 12'h000;
            2'd3: w_rgb = r_pix;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bx_nxt    = w_line_end ? 16'd0 : r_bx + 16'd1;
        w_ly_nxt    = !w_line_end ? r_ly : (w_state_end ? 16'd0 : r_ly + 16'd1);
        w_vsync_nxt = 1'b0;
        w_href_nxt  = 1'b0;
        w_dout_nxt  = 8'h00;
        w_fd_nxt    = 1'b0;
        w_start     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: begin
                w_bx_nxt = 16'd0;
                w_ly_nxt = 16'd0;
                w_start  = enable;
            end
            VSYNC: begin
                w_vsync_nxt = 1'b1;
                if (w_state_end) w_state_nxt = w_after_vs;
            end
            VBP: begin
                if (w_state_end) w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                w_href_nxt = w_in_line;
                if (w_in_line) w_dout_nxt = r_bx[0] ? w_rgb[7:0] : {4'h0, w_rgb[11:8]};
                if (w_state_end) begin
                    if (V_FP > 0) w_state_nxt = VFP;
                    else          w_frame_end = 1'b1;
                end
            end
            VFP: w_frame_end = w_state_end;
            default: w_state_nxt = IDLE;
        endcase
        // enable is only looked at here and in IDLE
        if (w_frame_end) begin
            w_fd_nxt    = 1'b1;
            w_start     = enable;
            w_state_nxt = IDLE;
        end
        if (w_start) w_state_nxt = w_first;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pclk    <= 1'b0;
            r_state   <= IDLE;
            r_bx      <= 16'd0;
            r_ly      <= 16'd0;
            r_vsync   <= 1'b0;
            r_href    <= 1'b0;
            r_dout    <= 8'h00;
            r_fd      <= 1'b0;
            r_pat     <= 2'd0;
            r_pix     <= 12'd0;
            r_bar_cnt <= 16'd0;
            r_bar     <= 3'd0;
        end else begin
            r_pclk <= ~r_pclk;
            r_fd   <= 1'b0;
            if (w_tick) begin
                r_state <= w_state_nxt;
                r_bx    <= w_bx_nxt;
                r_ly    <= w_ly_nxt;
                r_vsync <= w_vsync_nxt;
                r_href  <= w_href_nxt;
                r_dout  <= w_dout_nxt;
                r_fd    <= w_fd_nxt;
                if (w_start) r_pat <= pattern_sel;
                if (w_start)      r_pix <= 12'd0;
                else if (w_byte1) r_pix <= r_pix + 12'd1;
                // Bar index tracks x without a divider
                if (w_line_end || w_start) begin
                    r_bar_cnt <= 16'd0;
                    r_bar     <= 3'd0;
                end else if (w_byte1) begin
                    if (r_bar_cnt == 16'(BAR_W - 1)) begin
                        r_bar_cnt <= 16'd0;
                        if (r_bar != 3'd7) r_bar <= r_bar + 3'd1;
                    end else begin
                        r_bar_cnt <= r_bar_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign pclk_o     = r_pclk;
    assign vsync_o    = r_vsync;
    assign href_o     = r_href;
    assign dout       = r_dout;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_dvp_pattern_source.sv
// Bench for dvp_pattern_source: a small-geometry instance for frame timing,
// address pattern and async reset; a full-width instance for the pixel patterns.
`timescale 1ns/1ps
module tb_dvp_pattern_source;
    localparam int H1 = 8;
    localparam int V1 = 4;
    localparam int H2 = 320;
    localparam int V2 = 2;

    logic clk = 1'b0;
    logic clk_run = 1'b1;
    always #5 if (clk_run) clk = ~clk;

    logic       rst1, en1, p1_pclk, p1_vs, p1_href, p1_fd;
    logic [1:0] sel1;
    logic [7:0] p1_dout;
    logic       rst2, en2, p2_pclk, p2_vs, p2_href, p2_fd;
    logic [1:0] sel2;
    logic [7:0] p2_dout;

    dvp_pattern_source #(.H_ACTIVE(H1), .V_ACTIVE(V1), .H_BLANK(4),
                         .VSYNC_LINES(1), .V_BP(1), .V_FP(1)) u_small (
        .clk(clk), .rst(rst1), .enable(en1), .pattern_sel(sel1),
        .pclk_o(p1_pclk), .vsync_o(p1_vs), .href_o(p1_href),
        .dout(p1_dout), .frame_done(p1_fd));

    dvp_pattern_source #(.H_ACTIVE(H2), .V_ACTIVE(V2), .H_BLANK(4),
                         .VSYNC_LINES(1), .V_BP(1), .V_FP(1)) u_wide (
        .clk(clk), .rst(rst2), .enable(en2), .pattern_sel(sel2),
        .pclk_o(p2_pclk), .vsync_o(p2_vs), .href_o(p2_href),
        .dout(p2_dout), .frame_done(p2_fd));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor for the small instance ----------------
    int cyc = 0;
    int vs_rise[$], vs_fall[$], hr_rise[$], hr_fall[$], fd_at[$];
    int fd_hi_total = 0;
    logic [7:0] cap1 [V1][2*H1];
    logic [7:0] m1_fall_dout = 8'hEE;

    initial begin
        int  y, b;
        logic vs_d, hr_d, fd_d;
        y = -1; b = 0; vs_d = 0; hr_d = 0; fd_d = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst1) begin
                vs_d = 0; hr_d = 0; fd_d = 0;
            end else begin
                if (p1_vs && !vs_d) begin vs_rise.push_back(cyc); y = -1; end
                if (!p1_vs && vs_d) vs_fall.push_back(cyc);
                if (p1_href && !hr_d) begin hr_rise.push_back(cyc); y++; b = 0; end
                if (!p1_href && hr_d) begin hr_fall.push_back(cyc); m1_fall_dout = p1_dout; end
                if (p1_href && p1_pclk) begin
                    if (y >= 0 && y < V1 && b < 2*H1) cap1[y][b] = p1_dout;
                    b++;
                end
                if (p1_fd && !fd_d) fd_at.push_back(cyc);
                if (p1_fd) fd_hi_total++;
                vs_d = p1_vs; hr_d = p1_href; fd_d = p1_fd;
            end
        end
    end

    // ---------------- monitor for the wide instance ----------------
    int fd2_cnt = 0;
    int vs2_rises = 0;
    logic [7:0] cap2 [V2][2*H2];

    initial begin
        int  y, b;
        logic vs_d, hr_d, fd_d;
        y = -1; b = 0; vs_d = 0; hr_d = 0; fd_d = 0;
        forever begin
            @(negedge clk);
            if (!rst2) begin
                if (p2_vs && !vs_d) begin
                    vs2_rises++; y = -1;
                    for (int i = 0; i < V2; i++)
                        for (int j = 0; j < 2*H2; j++) cap2[i][j] = 8'hEE;
                end
                if (p2_href && !hr_d) begin y++; b = 0; end
                if (p2_href && p2_pclk) begin
                    if (y >= 0 && y < V2 && b < 2*H2) cap2[y][b] = p2_dout;
                    b++;
                end
                if (p2_fd && !fd_d) fd2_cnt++;
                vs_d = p2_vs; hr_d = p2_href; fd_d = p2_fd;
            end
        end
    end

    typedef struct {
        int         pat;
        int         x;
        int         y;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;
    vec_t tbl [20];

    task automatic check_pat(input int pat);
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].pat == pat) begin
                chk($sformatf("pat%0d_x%0d_y%0d_b0", pat, tbl[i].x, tbl[i].y),
                    int'(cap2[tbl[i].y][2*tbl[i].x]), int'(tbl[i].b0));
                chk($sformatf("pat%0d_x%0d_y%0d_b1", pat, tbl[i].x, tbl[i].y),
                    int'(cap2[tbl[i].y][2*tbl[i].x+1]), int'(tbl[i].b1));
            end
        end
    endtask

    initial begin
        int n, tog_bad, idle_bad, hr_seen;
        logic prev;

        tbl[0]  = '{0,   0, 0, 8'h0F, 8'hFF};
        tbl[1]  = '{0,  39, 0, 8'h0F, 8'hFF};
        tbl[2]  = '{0,  40, 0, 8'h0F, 8'hF0};
        tbl[3]  = '{0,  80, 1, 8'h00, 8'hFF};
        tbl[4]  = '{0, 120, 0, 8'h00, 8'hF0};
        tbl[5]  = '{0, 160, 1, 8'h0F, 8'h0F};
        tbl[6]  = '{0, 200, 0, 8'h0F, 8'h00};
        tbl[7]  = '{0, 240, 1, 8'h00, 8'h0F};
        tbl[8]  = '{0, 280, 0, 8'h00, 8'h00};
        tbl[9]  = '{0, 319, 1, 8'h00, 8'h00};
        tbl[10] = '{2,   0, 0, 8'h00, 8'h00};
        tbl[11] = '{2,  16, 0, 8'h0F, 8'hFF};
        tbl[12] = '{2,  31, 1, 8'h0F, 8'hFF};
        tbl[13] = '{2,  32, 1, 8'h00, 8'h00};
        tbl[14] = '{2,  48, 0, 8'h0F, 8'hFF};
        tbl[15] = '{1,   0, 0, 8'h00, 8'h00};
        tbl[16] = '{1,  16, 0, 8'h01, 8'h11};
        tbl[17] = '{1, 255, 1, 8'h0F, 8'hFF};
        tbl[18] = '{1, 256, 0, 8'h00, 8'h00};
        tbl[19] = '{1, 300, 1, 8'h02, 8'h22};

        rst1 = 1; en1 = 0; sel1 = 0;
        rst2 = 1; en2 = 0; sel2 = 0;
        repeat (3) @(negedge clk);
        chk("reset_pclk",  int'(p1_pclk), 0);
        chk("reset_vsync", int'(p1_vs), 0);
        chk("reset_href",  int'(p1_href), 0);
        chk("reset_dout",  int'(p1_dout), 0);
        chk("reset_fd",    int'(p1_fd), 0);
        rst1 = 0; rst2 = 0;

        // idle: pclk toggles every clk, everything else low
        tog_bad = 0; idle_bad = 0; prev = p1_pclk;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (p1_pclk == prev) tog_bad++;
            if (p1_vs || p1_href || p1_fd || p1_dout != 8'h00) idle_bad++;
            prev = p1_pclk;
        end
        chk("idle_pclk_toggle", tog_bad, 0);
        chk("idle_outputs_low", idle_bad, 0);

        // frame timing + address pattern, small geometry (L = 20 ticks = 40 clks)
        sel1 = 2'd3; en1 = 1;
        n = 0;
        while (fd_at.size() < 1 && n < 1000) begin @(negedge clk); n++; end
        chk("frame1_done_in_time", int'(fd_at.size() >= 1), 1);
        chk("href_pulse_count", hr_fall.size(), V1);
        if (vs_rise.size() >= 1 && vs_fall.size() >= 1 && hr_rise.size() >= V1 &&
            hr_fall.size() >= V1 && fd_at.size() >= 1) begin
            chk("vsync_width_clks", vs_fall[0] - vs_rise[0], 40);
            chk("vbp_to_href_clks", hr_rise[0] - vs_fall[0], 40);
            for (int k = 0; k < V1; k++)
                chk($sformatf("href%0d_width_clks", k), hr_fall[k] - hr_rise[k], 32);
            for (int k = 0; k < V1 - 1; k++)
                chk($sformatf("href%0d_gap_clks", k), hr_rise[k+1] - hr_fall[k], 8);
            // frame_done lands on the 140th tick of the frame
            chk("vsync_to_frame_done_clks", fd_at[0] - vs_rise[0], 278);
        end else begin
            chk("frame1_events_present", 0, 1);
        end
        chk("frame_done_width_clks", fd_hi_total, 1);
        chk("after_last_byte_dout", int'(m1_fall_dout), 0);
        for (int y = 0; y < V1; y++)
            for (int x = 0; x < H1; x++) begin
                chk($sformatf("addr_y%0d_x%0d_b0", y, x), int'(cap1[y][2*x]), 0);
                chk($sformatf("addr_y%0d_x%0d_b1", y, x), int'(cap1[y][2*x+1]), y*H1 + x);
            end

        // enable still high: next frame follows back to back
        n = 0;
        while (vs_rise.size() < 2 && n < 100) begin @(negedge clk); n++; end
        if (vs_rise.size() >= 2) chk("frame_period_clks", vs_rise[1] - vs_rise[0], 280);
        else                     chk("second_frame_started", 0, 1);

        // async reset in an active line with the clock stopped
        n = 0;
        while (!p1_href && n < 200) begin @(negedge clk); n++; end
        chk("href_high_before_rst", int'(p1_href), 1);
        clk_run = 0;
        #2 rst1 = 1;
        #1;
        chk("async_rst_href",  int'(p1_href), 0);
        chk("async_rst_dout",  int'(p1_dout), 0);
        chk("async_rst_vsync", int'(p1_vs), 0);
        chk("async_rst_pclk",  int'(p1_pclk), 0);
        #10 clk_run = 1;
        repeat (4) @(negedge clk);
        rst1 = 0;
        n = 0; hr_seen = 0;
        while (!p1_vs && n < 20) begin
            @(negedge clk); n++;
            if (p1_href) hr_seen = 1;
        end
        chk("restart_vsync_clks", n, 4);
        chk("restart_no_href_first", hr_seen, 0);
        en1 = 0;

        // frame A: colour bars; enable dropped and pattern switched mid-frame
        sel2 = 2'd0; en2 = 1;
        n = 0;
        while (vs2_rises < 1 && n < 20) begin @(negedge clk); n++; end
        chk("frameA_vsync_seen", vs2_rises, 1);
        en2 = 0;
        n = 0;
        while (!p2_href && n < 3000) begin @(negedge clk); n++; end
        sel2 = 2'd2;
        n = 0;
        while (fd2_cnt < 1 && n < 8000) begin @(negedge clk); n++; end
        repeat (400) @(negedge clk);
        chk("frameA_done_count", fd2_cnt, 1);
        chk("frameA_then_idle", vs2_rises, 1);
        check_pat(0);

        // frame B: pattern_sel=2 picked up on re-enable
        en2 = 1;
        n = 0;
        while (vs2_rises < 2 && n < 20) begin @(negedge clk); n++; end
        en2 = 0;
        n = 0;
        while (fd2_cnt < 2 && n < 8000) begin @(negedge clk); n++; end
        chk("frameB_done_count", fd2_cnt, 2);
        check_pat(2);

        // frame C: gray gradient
        sel2 = 2'd1; en2 = 1;
        n = 0;
        while (vs2_rises < 3 && n < 20) begin @(negedge clk); n++; end
        en2 = 0;
        n = 0;
        while (fd2_cnt < 3 && n < 8000) begin @(negedge clk); n++; end
        chk("frameC_done_count", fd2_cnt, 3);
        check_pat(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
